regfile_write_arbiter: RTL and testbench

- Round-robin scheduler that shares the single write port of the 8-entry register file among NUM_REQ requesters (ALU writeback, load unit, CSR path, and so on).
- Each cycle it grants at most one requester over a valid/ready handshake.
- It registers the winning address and data, then drives the write-port enable and the 3-bit address into the register file's write decoder.
- It also provides a stall input and a saturating write counter for debug.

---
 rtl/regfile_write_arbiter.sv | 76 +++++++
 tb/tb_regfile_write_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters.
// Latency: one cycle from a transfer (req_valid & req_ready) to wr_en/wr_addr/wr_data.
// Backpressure: wr_stall or rst drops every req_ready; requesters hold their request until granted.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 3,
    parameter int CNT_W   = 16,
    // Kept at least 1 bit wide so NUM_REQ=1 still has a legal index/pointer width
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wr_stall,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [SRC_W-1:0]          wr_src,
    output logic [CNT_W-1:0]          wr_count
);

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] nxt_ptr;
    logic             grant_vld;

    // Search upward from rr_ptr with wrap; the first valid requester wins
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        if (!wr_stall && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!grant_vld && req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SRC_W'(idx);
                end
            end
        end
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign nxt_ptr = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_src   <= '0;
            wr_count <= '0;
        end else begin
            wr_en <= grant_vld;
            if (grant_vld) begin
                rr_ptr  <= nxt_ptr;
                wr_addr <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                wr_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
                wr_src  <= grant_idx;
                if (wr_count != {CNT_W{1'b1}}) begin
                    wr_count <= wr_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: inputs change and outputs are checked on the falling edge.
module tb_regfile_write_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [11:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         wr_stall;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [1:0]   wr_src;
    logic [15:0]  wr_count;

    int vectors = 0;
    int errs    = 0;

    regfile_write_arbiter #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(3), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_src    (wr_src),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [31:0] d);
        req_addr[i*3 +: 3]  = a;
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        wr_stall  = 1'b0;

        // Reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("idle_wr_en", wr_en, 0);
            chk("idle_wr_addr", wr_addr, 0);
            chk("idle_wr_count", wr_count, 0);
            chk("idle_req_ready", req_ready, 4'b0000);
        end
        chk("idle_wr_data", wr_data, 0);
        chk("idle_wr_src", wr_src, 0);

        // Single request from requester 2
        @(negedge clk);
        req_valid = 4'b0100;
        set_req(2, 3'd5, 32'hDEADBEEF);
        #1 chk("single_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("single_wr_en", wr_en, 1);
        chk("single_wr_addr", wr_addr, 5);
        chk("single_wr_data", wr_data, 32'hDEADBEEF);
        chk("single_wr_src", wr_src, 2);
        @(negedge clk); #1;
        chk("single_wr_en_drop", wr_en, 0);
        chk("single_wr_count", wr_count, 1);

        // Fairness from reset: all four valid continuously
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 32'hA0 + i);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("rr_ready", req_ready, 4'b0001 << (k % 4));
            if (k > 0) begin
                chk("rr_wr_en", wr_en, 1);
                chk("rr_wr_src", wr_src, (k - 1) % 4);
                chk("rr_wr_addr", wr_addr, ((k - 1) % 4) + 1);
            end else begin
                chk("rr_first_wr_en", wr_en, 0);
            end
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("rr_last_wr_en", wr_en, 1);
        chk("rr_last_wr_src", wr_src, 1);
        chk("rr_last_wr_data", wr_data, 32'hA1);
        chk("rr_wr_count", wr_count, 6);
        @(negedge clk); #1;
        chk("rr_wr_en_drop", wr_en, 0);

        // Stall: requester 1 held for three stalled cycles (pointer is 2)
        @(negedge clk);
        set_req(1, 3'd6, 32'h5555);
        req_valid = 4'b0010;
        wr_stall  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("stall_ready", req_ready, 4'b0000);
            chk("stall_wr_en", wr_en, 0);
        end
        @(negedge clk);
        wr_stall = 1'b0;
        #1 chk("stall_release_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("stall_wr_en", wr_en, 1);
        chk("stall_wr_addr", wr_addr, 6);
        chk("stall_wr_data", wr_data, 32'h5555);
        chk("stall_wr_src", wr_src, 1);
        chk("stall_wr_count", wr_count, 7);

        // Move pointer to 3 via a transfer from requester 2
        @(negedge clk);
        req_valid = 4'b0100;
        #1 chk("ptr3_ready", req_ready, 4'b0100);

        // Same address from requesters 0 and 3, pointer at 3
        @(negedge clk);
        set_req(0, 3'd7, 32'h11);
        set_req(3, 3'd7, 32'h33);
        req_valid = 4'b1001;
        #1 chk("same_ready_first", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        chk("same_ready_second", req_ready, 4'b0001);
        chk("same_w1_src", wr_src, 3);
        chk("same_w1_data", wr_data, 32'h33);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("same_w2_en", wr_en, 1);
        chk("same_w2_addr", wr_addr, 7);
        chk("same_w2_src", wr_src, 0);
        chk("same_w2_data", wr_data, 32'h11);
        chk("same_wr_count", wr_count, 10);

        // Reset mid-burst while requester 1 is granted (pointer is 1)
        @(negedge clk);
        set_req(1, 3'd2, 32'hBAD);
        req_valid = 4'b0010;
        #1 chk("rstmid_ready_pre", req_ready, 4'b0010);
        #1 rst = 1'b1;
        #1 chk("rstmid_ready_rst", req_ready, 4'b0000);
        @(negedge clk); #1;
        chk("rstmid_wr_en", wr_en, 0);
        chk("rstmid_wr_addr", wr_addr, 0);
        chk("rstmid_wr_data", wr_data, 0);
        chk("rstmid_wr_src", wr_src, 0);
        chk("rstmid_wr_count", wr_count, 0);
        rst       = 1'b0;
        req_valid = 4'b1001;
        #1 chk("rstmid_restart_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("rstmid_restart_wr_en", wr_en, 1);
        chk("rstmid_restart_wr_src", wr_src, 0);
        chk("rstmid_restart_count", wr_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
